// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: RV32I opcodes, NOP encoding and fetch FSM states.
// MISALIGN_TRAP_EN adds the HALT state used by the misaligned-target trap.
package fetch_unit_pkg;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef MISALIGN_TRAP_EN
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} fetch_state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} fetch_state_t;
`endif

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: pc+4, word-aligned branch/jump target, and
// (with MISALIGN_TRAP_EN) the misaligned-target flag.
module pc_next
   import fetch_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic            pcSrc,
   input  logic [XLEN-1:0] pcTarget,
   output logic [XLEN-1:0] pcPlus4,
`ifdef MISALIGN_TRAP_EN
   output logic            misaligned,
`endif
   output logic [XLEN-1:0] pcNext
);

   logic [XLEN-1:0] target_aligned;

   always_comb begin
      pcPlus4        = pc + XLEN'(4);
      // Mask rather than slice so the low target bits are consumed in every build.
      target_aligned = pcTarget & ~XLEN'(3);
      pcNext         = pcSrc ? target_aligned : pcPlus4;
`ifdef MISALIGN_TRAP_EN
      misaligned     = pcSrc & (pcTarget[1:0] != 2'b00);
`endif
   end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch stage: PC, instruction register and IDLE/FETCH/EXEC FSM.
// Build option MISALIGN_TRAP_EN: trap to HALT on a misaligned taken target.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pcSrc,
   input  logic [XLEN-1:0] pcTarget,
   input  logic            stall,
   output logic            imemReq,
   output logic [XLEN-1:0] imemAddr,
   input  logic            imemAck,
   input  logic [31:0]     imemData,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcPlus4,
   output logic [31:0]     instr,
   output logic [6:0]      op,
   output logic [2:0]      f3,
   output logic            f7,
`ifdef MISALIGN_TRAP_EN
   output logic            misaligned,
`endif
   output logic            instrValid
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic            load_instr;
   logic            load_pc;
`ifdef MISALIGN_TRAP_EN
   logic            target_misaligned;
   logic            set_trap;
`endif

   pc_next #(
      .XLEN(XLEN)
   ) u_pc_next (
      .pc        (pc),
      .pcSrc     (pcSrc),
      .pcTarget  (pcTarget),
      .pcPlus4   (pcPlus4),
`ifdef MISALIGN_TRAP_EN
      .misaligned(target_misaligned),
`endif
      .pcNext    (pc_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
         instr <= NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
         misaligned <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (load_pc)
            pc <= pc_nxt;
         if (load_instr)
            instr <= imemData;
`ifdef MISALIGN_TRAP_EN
         if (set_trap)
            misaligned <= 1'b1;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      load_instr = 1'b0;
      load_pc    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      set_trap   = 1'b0;
`endif
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            if (imemAck) begin
               load_instr = 1'b1;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
`ifdef MISALIGN_TRAP_EN
               if (target_misaligned) begin
                  set_trap  = 1'b1;
                  state_nxt = HALT;
               end else begin
                  load_pc   = 1'b1;
                  state_nxt = FETCH;
               end
`else
               load_pc   = 1'b1;
               state_nxt = FETCH;
`endif
            end
         end
`ifdef MISALIGN_TRAP_EN
         HALT:  state_nxt = HALT;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imemReq    = (state == FETCH);
      imemAddr   = pc;
      instrValid = (state == EXEC);
      op         = instr[6:0];
      f3         = instr[14:12];
      f7         = instr[30];
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, zero-wait and wait-state fetch,
// stall/branch, PC wrap, reset mid-fetch, and the MISALIGN_TRAP_EN trap when built with it.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcSrc;
   logic [31:0] pcTarget;
   logic        stall;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic        f7;
   logic        instrValid;
`ifdef MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   fetch_unit #(
      .XLEN    (32),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pcSrc     (pcSrc),
      .pcTarget  (pcTarget),
      .stall     (stall),
      .imemReq   (imemReq),
      .imemAddr  (imemAddr),
      .imemAck   (imemAck),
      .imemData  (imemData),
      .pc        (pc),
      .pcPlus4   (pcPlus4),
      .instr     (instr),
      .op        (op),
      .f3        (f3),
      .f7        (f7),
`ifdef MISALIGN_TRAP_EN
      .misaligned(misaligned),
`endif
      .instrValid(instrValid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; pcSrc = 1'b0; pcTarget = '0; stall = 1'b0;
      imemAck = 1'b0; imemData = '0;

      repeat (2) step();
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h13);
      check("rst_req", 32'(imemReq), 32'h0);
      check("rst_valid", 32'(instrValid), 32'h0);
      check("rst_op", 32'(op), 32'h13);

      // IDLE -> FETCH one cycle after release
      rst = 1'b0;
      step();
      check("fetch0_req", 32'(imemReq), 32'h1);
      check("fetch0_addr", imemAddr, 32'h0);
      check("fetch0_valid", 32'(instrValid), 32'h0);

      // zero-wait memory: ack held high throughout
      imemAck = 1'b1; imemData = 32'h0050_0093;
      step();
      check("zw_valid", 32'(instrValid), 32'h1);
      check("zw_op", 32'(op), 32'h13);
      check("zw_instr", instr, 32'h0050_0093);
      check("zw_pc0", pc, 32'h0);
      check("zw_req_exec", 32'(imemReq), 32'h0);
      imemData = 32'hFFFF_FFFF;           // must be ignored in EXEC
      step();
      check("zw_addr4", imemAddr, 32'h4);
      check("zw_req4", 32'(imemReq), 32'h1);
      check("zw_exec_ack_ignored", instr, 32'h0050_0093);
      imemData = 32'h0050_0093;
      step();
      check("zw_pc4", pc, 32'h4);
      step();
      check("zw_addr8", imemAddr, 32'h8);

      // wait states: no ack for 3 fetch cycles
      imemAck = 1'b0; imemData = 32'h4020_8033;
      for (int i = 0; i < 3; i++) begin
         check("ws_req", 32'(imemReq), 32'h1);
         check("ws_addr", imemAddr, 32'h8);
         check("ws_instr_hold", instr, 32'h0050_0093);
         check("ws_valid", 32'(instrValid), 32'h0);
         step();
      end
      imemAck = 1'b1;
      step();
      check("ws_instr", instr, 32'h4020_8033);
      check("ws_op", 32'(op), 32'h33);
      check("ws_f3", 32'(f3), 32'h0);
      check("ws_f7", 32'(f7), 32'h1);
      check("ws_pc", pc, 32'h8);

      // stall then branch to 0x40
      stall = 1'b1; pcSrc = 1'b1; pcTarget = 32'h40; imemData = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_pc", pc, 32'h8);
         check("stall_instr", instr, 32'h4020_8033);
         check("stall_valid", 32'(instrValid), 32'h1);
         check("stall_req", 32'(imemReq), 32'h0);
      end
      stall = 1'b0;
      step();
      check("br_addr", imemAddr, 32'h40);
      check("br_req", 32'(imemReq), 32'h1);
      // pcSrc/pcTarget must be ignored while in FETCH
      pcTarget = 32'h100; imemData = 32'h0000_006F;
      step();
      check("br_pc_exec", pc, 32'h40);
      check("br_op", 32'(op), 32'h6F);

      // misaligned target 0x42
      pcSrc = 1'b1; pcTarget = 32'h42;
      step();
`ifdef MISALIGN_TRAP_EN
      check("mis_flag", 32'(misaligned), 32'h1);
      check("mis_req", 32'(imemReq), 32'h0);
      check("mis_valid", 32'(instrValid), 32'h0);
      check("mis_pc", pc, 32'h40);
      pcSrc = 1'b0;
      repeat (2) step();
      check("halt_req", 32'(imemReq), 32'h0);
      check("halt_pc", pc, 32'h40);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("halt_rst_flag", 32'(misaligned), 32'h0);
      check("halt_rst_pc", pc, 32'h0);
`else
      check("mis_addr", imemAddr, 32'h40);
      check("mis_req", 32'(imemReq), 32'h1);

      // branch to 0xFFFFFFFF (aligned to ...FC) then wrap via pc+4
      pcTarget = 32'hFFFF_FFFF; imemData = 32'h0000_0063;
      step();
      check("wrap_pc40", pc, 32'h40);
      step();
      check("wrap_addr", imemAddr, 32'hFFFF_FFFC);
      check("wrap_plus4", pcPlus4, 32'h0);
      pcSrc = 1'b0;
      step();
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_instr", instr, 32'h0000_0063);
      step();
      check("wrap_addr0", imemAddr, 32'h0);
      check("wrap_req0", 32'(imemReq), 32'h1);

      // reset during FETCH, then ack while in IDLE
      imemAck = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; imemAck = 1'b1; imemData = 32'hCAFE_BABE;
      check("midrst_req", 32'(imemReq), 32'h0);
      check("midrst_instr", instr, 32'h13);
      check("midrst_valid", 32'(instrValid), 32'h0);
      step();
      check("idle_ack_instr", instr, 32'h13);
      check("idle_ack_req", 32'(imemReq), 32'h1);
      step();
      check("refetch_instr", instr, 32'hCAFE_BABE);
      check("refetch_valid", 32'(instrValid), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
